// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-issue MIPS core.
// Sequences fetch/decode/execute/memory/write-back and drives datapath enables and selects.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] npc_sel,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src_imm,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic       mem_write,
  output logic       instr_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_rtype;
  logic w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
  logic w_nop;

  assign w_rtype = (opcode == 6'h00);
  assign w_addu  = w_rtype && (funct == 6'h21);
  assign w_subu  = w_rtype && (funct == 6'h23);
  assign w_jr    = w_rtype && (funct == 6'h08);
  assign w_ori   = (opcode == 6'h0d);
  assign w_lui   = (opcode == 6'h0f);
  assign w_lw    = (opcode == 6'h23);
  assign w_sw    = (opcode == 6'h2b);
  assign w_beq   = (opcode == 6'h04);
  assign w_j     = (opcode == 6'h02);
  assign w_jal   = (opcode == 6'h03);
  assign w_nop   = !(w_addu || w_subu || w_jr || w_ori || w_lui ||
                     w_lw || w_sw || w_beq || w_j || w_jal);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_j || w_jr || w_nop) w_next = S_FETCH;
        else if (w_jal)           w_next = S_WB;
        else                      w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_lw || w_sw)                              w_next = S_MEM;
        else if (w_addu || w_subu || w_ori || w_lui)   w_next = S_WB;
        else                                           w_next = S_FETCH;
      end
      S_MEM:    w_next = w_lw ? S_WB : S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // All enables and selects are gated off while reset is high so an abandoned
  // instruction cannot commit anything in the reset cycle.
  always_comb begin
    pc_write    = 1'b0;
    npc_sel     = 2'd0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    wd_sel      = 2'd0;
    alu_src_imm = 1'b0;
    ext_op      = 1'b0;
    alu_op      = 2'd0;
    mem_write   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH:  ir_write = 1'b1;
        S_DECODE: begin
          if (w_j) begin
            pc_write = 1'b1;
            npc_sel  = 2'd2;
          end else if (w_jr) begin
            pc_write = 1'b1;
            npc_sel  = 2'd3;
          end else if (w_nop) begin
            pc_write = 1'b1;
          end
        end
        S_EXEC, S_MEM, S_WB: begin
          // ALU selects follow the instruction and stay put through MEM/WB.
          if (w_subu)            alu_op = 2'd1;
          if (w_ori) begin
            alu_op      = 2'd2;
            alu_src_imm = 1'b1;
          end
          if (w_lui) begin
            alu_op      = 2'd3;
            alu_src_imm = 1'b1;
          end
          if (w_lw || w_sw) begin
            alu_src_imm = 1'b1;
            ext_op      = 1'b1;
          end
          if (w_beq) begin
            alu_op = 2'd1;
            ext_op = 1'b1;
          end
          if (r_state == S_EXEC && w_beq) begin
            pc_write = 1'b1;
            npc_sel  = zero ? 2'd1 : 2'd0;
          end
          if (r_state == S_MEM && w_sw) begin
            mem_write = 1'b1;
            pc_write  = 1'b1;
          end
          if (r_state == S_WB) begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            if (w_jal) begin
              npc_sel = 2'd2;
              reg_dst = 2'd2;
              wd_sel  = 2'd2;
            end else if (w_addu || w_subu) begin
              reg_dst = 2'd1;
            end else if (w_lw) begin
              wd_sel = 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_done = pc_write;
  assign state      = r_state;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the single-issue MIPS core. It sequences instruction fetch, GRF read, ALU execute, data-memory access and GRF write-back. It drives the write enables and mux selects for the PC, IR, GRF, ALU and DM from the current state and the latched IR fields. It owns no datapath storage; the GRF, IR, PC and DM sit beside it.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces state to FETCH
- opcode  in  6  IR[31:26], stable from the cycle after FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU equal flag (GRF[rs] == GRF[rt]), valid in EXEC
- pc_write  out  1  PC <- NPC(npc_sel) at next rising edge
- npc_sel  out  2  0 PC+4, 1 PC+4+(sext(imm)<<2), 2 {PC[31:28],imm26,2'b0}, 3 GRF[rs]
- ir_write  out  1  IR <- IM[PC]
- reg_write  out  1  GRF write enable (GRF samples on falling edge within the cycle)
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- wd_sel  out  2  0 ALU result, 1 DM read data, 2 PC+4
- alu_src_imm  out  1  ALU B = extended imm (else GRF[rt])
- ext_op  out  1  0 zero-extend, 1 sign-extend
- alu_op  out  2  0 add, 1 sub, 2 or, 3 lui (B<<16)
- mem_write  out  1  DM write enable
- instr_done  out  1  equals pc_write; one pulse per retired instruction
- state  out  3  current state encoding, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5-7 are unreachable and go to FETCH.
- Decode set:
  - R-type (op 0): addu funct 0x21, subu funct 0x23, jr funct 0x08
  - I-type: ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04
  - J-type: j 0x02, jal 0x03
  - Every other encoding, including all-zero nop, is NOP-class.
- FETCH: ir_write=1. Go to DECODE.
- DECODE: GRF is read combinationally from rs/rt.
  - j: pc_write=1, npc_sel=2, go to FETCH.
  - jr: pc_write=1, npc_sel=3, go to FETCH.
  - NOP-class: pc_write=1, npc_sel=0, go to FETCH.
  - jal: go to WB.
  - All others: go to EXEC.
- EXEC: selects per instruction.
  - addu: alu_op 0, reg B.
  - subu: alu_op 1, reg B.
  - ori: alu_op 2, imm, ext 0.
  - lui: alu_op 3, imm.
  - lw/sw: alu_op 0, imm, ext 1.
  - beq: alu_op 1, reg B, ext 1, pc_write=1, npc_sel = zero ? 1 : 0, go to FETCH.
  - lw/sw go to MEM; others go to WB.
- EXEC selects are held through MEM and WB of the same instruction.
- MEM:
  - sw: mem_write=1, pc_write=1, npc_sel=0, go to FETCH.
  - lw: go to WB.
- WB: reg_write=1 and pc_write=1, then go to FETCH.
  - npc_sel is 0, except jal which uses 2.
  - addu/subu: reg_dst 1, wd_sel 0.
  - ori/lui: reg_dst 0, wd_sel 0.
  - lw: reg_dst 0, wd_sel 1.
  - jal: reg_dst 2, wd_sel 2.
- The PC is updated only in an instruction's final state, so PC+4 used for the jal link is the jal address + 4.
- Writes to $0 are issued normally; the GRF discards them.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational from the state register and opcode/funct. state and instr_done are registered-state derived.
- Cycles per instruction:
  - j, jr, NOP-class: 2
  - beq, jal: 3
  - addu, subu, ori, lui, sw: 4
  - lw: 5
- Exactly one pc_write pulse per instruction, in its last cycle.
- reg_write and mem_write are each high for at most one cycle per instruction, never both.
- While reset=1: state becomes FETCH at the edge, and all enables are forced 0 (pc_write, ir_write, reg_write, mem_write, instr_done). Selects are 0.
- First cycle after reset deasserts: FETCH with ir_write=1.
- Reset mid-instruction (any state): no write enable asserts in the reset cycle. The partial instruction is abandoned, and the next cycle is FETCH.
- beq uses zero as sampled in the EXEC cycle. Taken and not-taken both take 3 cycles.

## Test plan
- addu $3,$1,$2 with GRF $1=5, $2=7 -> states 0,1,2,4,0. reg_write only in cycle 4, with reg_dst=1 and wd_sel=0. $3=12. One instr_done.
- lw then sw to the same address -> lw takes 5 cycles with wd_sel=1 in WB. sw takes 4 cycles with mem_write=1 only in MEM and reg_write never high.
- beq with zero=1, then beq with zero=0 -> both take 3 cycles. npc_sel is 1 for the first and 0 for the second. No reg_write or mem_write.
- jal at PC 0x3000 -> 3 cycles. In WB: reg_dst=2, wd_sel=2 (writes 0x3004 to $31), pc_write=1, npc_sel=2. Follow with jr $31 -> 2 cycles, npc_sel=3.
- opcode 0x3f, and the all-zero word -> each takes 2 cycles with only ir_write in FETCH and pc_write (npc_sel 0) in DECODE.
- reset asserted during the MEM cycle of sw -> mem_write stays 0 in that cycle. state=0 the next cycle. Execution restarts with a FETCH ir_write pulse after deassertion.
